// File: rtl/piezo_sound_if.sv
// ---------------------------------------------------------------------------
// piezo_sound_if
//   Bundles the sound-request and speaker signals of the piezo sequencer.
//   master: the game-side requester (drives call/sound_code, observes outputs)
//   slave : the piezo_sound sequencer
//   Signals:
//     call        toggle trigger, every level change requests playback
//     sound_code  effect select (0 game over, 1 step tick, 2 apple, 3 silence)
//     speaker     square-wave drive to the piezo, 0 when silent
//     busy        (PIEZO_BUSY_EN only) high while an effect is playing
// ---------------------------------------------------------------------------
interface piezo_sound_if;
    logic       call;
    logic [1:0] sound_code;
    logic       speaker;
`ifdef PIEZO_BUSY_EN
    logic       busy;

    modport master (output call, output sound_code, input speaker, input busy);
    modport slave  (input call, input sound_code, output speaker, output busy);
`else
    modport master (output call, output sound_code, input speaker);
    modport slave  (input call, input sound_code, output speaker);
`endif
endinterface

// File: rtl/piezo_sound.sv
// ---------------------------------------------------------------------------
// piezo_sound
//   Sound-effect sequencer for the snake game. Every level change of
//   bus.call starts one of the canned effects chosen by bus.sound_code:
//     0 game-over melody (each note followed by GAP_MS of silence)
//     1 step tick
//     2 apple jingle
//     3 silence (aborts whatever is playing)
//   A new request always aborts the running effect.
//   Optional feature macro: PIEZO_BUSY_EN adds bus.busy (high in NOTE/GAP).
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    piezo_sound_if.slave: call, sound_code in; speaker (and busy) out
// Parameters
//   CLK_HZ clock frequency in Hz; all tone/duration counts derive from it
//   GAP_MS silence after every note of the game-over melody
// ---------------------------------------------------------------------------
module piezo_sound #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned GAP_MS = 50
) (
    input  logic           clk,
    input  logic           rst_n,
    piezo_sound_if.slave   bus
);

    localparam int unsigned MS_CYC = CLK_HZ / 1000;

    // Half periods of each tone, truncated at elaboration.
    localparam int unsigned H_311  = CLK_HZ / (2 * 311);
    localparam int unsigned H_392  = CLK_HZ / (2 * 392);
    localparam int unsigned H_466  = CLK_HZ / (2 * 466);
    localparam int unsigned H_1047 = CLK_HZ / (2 * 1047);
    localparam int unsigned H_2000 = CLK_HZ / (2 * 2000);
    localparam int unsigned H_2093 = CLK_HZ / (2 * 2093);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync3;
    logic [1:0]  r_code;
    logic [3:0]  r_idx;
    logic [31:0] r_tone_cnt;
    logic [31:0] r_ms_cnt;
    logic [31:0] r_ms_elapsed;
    logic        r_spk;

    logic        w_trig;
    logic [31:0] w_half;
    logic [31:0] w_dur_ms;
    logic        w_last;
    logic [31:0] w_seg_ms;
    logic        w_ms_wrap;
    logic        w_seg_end;
    logic        w_gap_after;

    // Any difference between the synchronised level and its delayed copy
    // is one request, regardless of direction.
    assign w_trig = r_sync2 ^ r_sync3;

    // Sequence ROM: tone half period, duration and last-note flag.
    always_comb begin
        w_half   = H_392;
        w_dur_ms = 32'd1;
        w_last   = 1'b1;
        case (r_code)
            2'd0: begin
                w_last = 1'b0;
                case (r_idx)
                    4'd0, 4'd1, 4'd2, 4'd5: begin w_half = H_392; w_dur_ms = 32'd500; end
                    4'd3, 4'd6:             begin w_half = H_311; w_dur_ms = 32'd350; end
                    4'd4, 4'd7:             begin w_half = H_466; w_dur_ms = 32'd150; end
                    4'd8: begin
                        w_half   = H_392;
                        w_dur_ms = 32'd650;
                        w_last   = 1'b1;
                    end
                    default: w_last = 1'b1;
                endcase
            end
            2'd1: begin
                w_half   = H_2000;
                w_dur_ms = 32'd15;
            end
            2'd2: begin
                if (r_idx == 4'd0) begin
                    w_half   = H_1047;
                    w_dur_ms = 32'd60;
                    w_last   = 1'b0;
                end else begin
                    w_half   = H_2093;
                    w_dur_ms = 32'd90;
                end
            end
            default: begin
                w_half   = H_392;
                w_dur_ms = 32'd1;
                w_last   = 1'b1;
            end
        endcase
    end

    assign w_seg_ms    = (r_state == ST_GAP) ? GAP_MS : w_dur_ms;
    assign w_ms_wrap   = (r_ms_cnt == MS_CYC - 1);
    assign w_seg_end   = w_ms_wrap && (r_ms_elapsed == w_seg_ms - 1);
    assign w_gap_after = (r_code == 2'd0) && (GAP_MS != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
            r_code       <= 2'd0;
            r_idx        <= '0;
            r_tone_cnt   <= '0;
            r_ms_cnt     <= '0;
            r_ms_elapsed <= '0;
            r_spk        <= 1'b0;
        end else begin
            r_sync1 <= bus.call;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            // A request is checked before any segment end so that a request
            // landing on the final note's last cycle still starts its effect.
            if (w_trig) begin
                r_code       <= bus.sound_code;
                r_idx        <= '0;
                r_tone_cnt   <= '0;
                r_ms_cnt     <= '0;
                r_ms_elapsed <= '0;
                r_spk        <= 1'b0;
                r_state      <= (bus.sound_code == 2'd3) ? ST_IDLE : ST_NOTE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_spk <= 1'b0;
                    end

                    ST_NOTE: begin
                        if (w_seg_end) begin
                            r_spk        <= 1'b0;
                            r_tone_cnt   <= '0;
                            r_ms_cnt     <= '0;
                            r_ms_elapsed <= '0;
                            if (w_gap_after) begin
                                r_state <= ST_GAP;
                            end else if (w_last) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_idx   <= r_idx + 4'd1;
                                r_state <= ST_NOTE;
                            end
                        end else begin
                            if (w_ms_wrap) begin
                                r_ms_cnt     <= '0;
                                r_ms_elapsed <= r_ms_elapsed + 32'd1;
                            end else begin
                                r_ms_cnt <= r_ms_cnt + 32'd1;
                            end
                            if (r_tone_cnt == w_half - 1) begin
                                r_tone_cnt <= '0;
                                r_spk      <= ~r_spk;
                            end else begin
                                r_tone_cnt <= r_tone_cnt + 32'd1;
                            end
                        end
                    end

                    ST_GAP: begin
                        r_spk <= 1'b0;
                        if (w_seg_end) begin
                            r_ms_cnt     <= '0;
                            r_ms_elapsed <= '0;
                            r_tone_cnt   <= '0;
                            if (w_last) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_idx   <= r_idx + 4'd1;
                                r_state <= ST_NOTE;
                            end
                        end else if (w_ms_wrap) begin
                            r_ms_cnt     <= '0;
                            r_ms_elapsed <= r_ms_elapsed + 32'd1;
                        end else begin
                            r_ms_cnt <= r_ms_cnt + 32'd1;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_spk   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.speaker = r_spk;

`ifdef PIEZO_BUSY_EN
    // Pure decode of the state register; low in reset since state is IDLE.
    assign bus.busy = (r_state != ST_IDLE);
`endif

endmodule

// File: tb/tb_piezo_sound.sv
// ---------------------------------------------------------------------------
// tb_piezo_sound
//   Directed bench for piezo_sound at CLK_HZ=10_000 (10 clk per ms),
//   GAP_MS=50 (500 clk). Expected half periods at this clock:
//     392 Hz -> 12, 311 Hz -> 16, 466 Hz -> 10,
//     2000 Hz -> 2, 1047 Hz -> 4, 2093 Hz -> 2
//   Each effect is aligned on the first rising edge of the speaker; from
//   there every cycle of every note/gap is predicted from H and duration.
// ---------------------------------------------------------------------------
module tb_piezo_sound;

    logic clk;
    logic rst_n;
    int unsigned cyc;
    int unsigned c0;
    int unsigned n_total;
    int unsigned n_pass;

    piezo_sound_if bus_if ();

    piezo_sound #(
        .CLK_HZ(10_000),
        .GAP_MS(50)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic trigger(input logic [1:0] code);
        bus_if.sound_code = code;
        bus_if.call       = ~bus_if.call;
        c0                = cyc;
    endtask

    // Wait for the first rising edge of the new effect, check its latency
    // from the call change (note start 1..4 clk after the change).
    task automatic wait_rise(input string tag, input int unsigned h);
        bit          found;
        int unsigned lat;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus_if.speaker === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_rise_seen"}, {31'd0, found}, 32'd1);
        lat = cyc - h - c0;
        chk({tag, "_latency_ok"}, {31'd0, (found && lat >= 1 && lat <= 4)}, 32'd1);
    endtask

    // Check cycles t0..t1-1 of a note of half period h and length l followed
    // by a gap of g cycles (t counted from the note-start edge).
    task automatic seg(input string tag, input int unsigned h, input int unsigned l,
                       input int unsigned g, input int unsigned t0, input int unsigned t1);
        int unsigned bad;
        int unsigned bbad;
        logic        e;
        bad  = 0;
        bbad = 0;
        for (int unsigned t = t0; t < t1; t++) begin
            e = (t < l) ? (((t / h) % 2) == 1) : 1'b0;
            if (bus_if.speaker !== e) bad++;
`ifdef PIEZO_BUSY_EN
            if (bus_if.busy !== 1'b1) bbad++;
`endif
            step();
        end
        chk({tag, "_tone"}, bad, 32'd0);
`ifdef PIEZO_BUSY_EN
        chk({tag, "_busy"}, bbad, 32'd0);
`else
        if (bbad != 0) $display("busy count %0d", bbad);
`endif
    endtask

    task automatic silent(input string tag, input int unsigned n);
        int unsigned bad;
        bad = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if (bus_if.speaker !== 1'b0) bad++;
`ifdef PIEZO_BUSY_EN
            if (bus_if.busy !== 1'b0) bad++;
`endif
            step();
        end
        chk({tag, "_silent"}, bad, 32'd0);
    endtask

    int unsigned mh [9] = '{12, 12, 12, 16, 10, 12, 16, 10, 12};
    int unsigned ml [9] = '{5000, 5000, 5000, 3500, 1500, 5000, 3500, 1500, 6500};

    initial begin
        cyc     = 0;
        c0      = 0;
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        bus_if.call       = 1'b0;
        bus_if.sound_code = 2'd0;

        // Reset state
        step();
        step();
        chk("reset_speaker", {31'd0, bus_if.speaker}, 32'd0);
`ifdef PIEZO_BUSY_EN
        chk("reset_busy", {31'd0, bus_if.busy}, 32'd0);
`endif
        rst_n = 1'b1;
        silent("post_reset", 50);

        // Step tick: 2000 Hz / 15 ms -> H=2, 150 clk
        trigger(2'd1);
        wait_rise("tick", 2);
        seg("tick", 2, 150, 0, 2, 150);
        silent("tick_end", 300);

        // Apple: 1047 Hz / 60 ms then 2093 Hz / 90 ms
        trigger(2'd2);
        wait_rise("apple", 4);
        seg("apple_n0", 4, 600, 0, 4, 600);
        seg("apple_n1", 2, 900, 0, 0, 900);
        silent("apple_end", 300);

        // Game-over melody, 500-clk gap after every note
        trigger(2'd0);
        wait_rise("melody", mh[0]);
        for (int i = 0; i < 9; i++) begin
            seg($sformatf("melody_n%0d", i), mh[i], ml[i], 500,
                (i == 0) ? mh[0] : 0, ml[i] + 500);
        end
        silent("melody_end", 300);

        // Abort melody in its first gap with a tick request
        trigger(2'd0);
        wait_rise("abort_mel", 12);
        seg("abort_mel_n0", 12, 5000, 500, 12, 5100);
        trigger(2'd1);
        wait_rise("abort_tick", 2);
        seg("abort_tick", 2, 150, 0, 2, 150);
        silent("abort_no_resume", 1000);

        // Code 3 during a tick silences it
        trigger(2'd1);
        wait_rise("pre_mute", 2);
        seg("pre_mute", 2, 150, 0, 2, 60);
        trigger(2'd3);
        for (int i = 0; i < 4; i++) step();
        silent("mute", 300);

        // Asynchronous reset mid-tone
        trigger(2'd1);
        wait_rise("pre_rst", 2);
        seg("pre_rst", 2, 150, 0, 2, 41);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_speaker", {31'd0, bus_if.speaker}, 32'd0);
`ifdef PIEZO_BUSY_EN
        chk("async_rst_busy", {31'd0, bus_if.busy}, 32'd0);
`endif
        bus_if.call = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        silent("rst_idle", 300);

        // call held high across reset release: exactly one trigger
        #2;
        rst_n = 1'b0;
        bus_if.call       = 1'b1;
        bus_if.sound_code = 2'd2;
        step();
        step();
        rst_n = 1'b1;
        c0    = cyc;
        wait_rise("rel_apple", 4);
        seg("rel_apple_n0", 4, 600, 0, 4, 600);
        seg("rel_apple_n1", 2, 900, 0, 0, 900);
        silent("rel_apple_end", 500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
